ibex_prefetch_ctrl: RTL and testbench

Request-side controller placed directly upstream of the instruction fetch FIFO. Issues word-aligned instruction-bus requests (req/gnt/rvalid protocol) and tracks up to NUM_REQS outstanding transactions. On a branch it clears the FIFO and discards stale responses. It forwards valid responses into the FIFO's push port and keeps the total of outstanding requests plus FIFO occupancy within capacity.

---
 rtl/ibex_prefetch_ctrl.sv | 119 +++++++++++
 tb/tb_ibex_prefetch_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction-bus request controller feeding the fetch FIFO: issues word-aligned
// requests, tracks outstanding transactions and discards responses made stale by branches.
module ibex_prefetch_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o
);

    logic [NUM_REQS-1:0] out_q, out_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic                pend_q, pend_d;
    logic                stored_q, stored_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;

    logic [31:0]         branch_addr;
    logic                new_req;
    logic                gnt_fire;
    logic                pop;
    logic                discard_new;
    logic                placed;
    logic                unused_fifo_busy;

    assign branch_addr      = {addr_i[31:2], 2'b00};
    assign unused_fifo_busy = ^fifo_busy_i;

    // Capacity: outstanding requests plus occupied FIFO entries stay within NUM_REQS+1.
    assign new_req = req_i & ~out_q[NUM_REQS-1] &
                     (branch_i | ~fifo_busy_i[NUM_REQS-1] | ~out_q[0]);

    assign instr_req_o  = new_req | pend_q;
    // A pending request keeps its address; a branch seen meanwhile is parked in stored_addr_q.
    assign instr_addr_o = (pend_q | ~branch_i) ? fetch_addr_q : branch_addr;
    assign gnt_fire     = instr_req_o & instr_gnt_i;
    assign pop          = instr_rvalid_i & out_q[0];
    assign discard_new  = pend_q & (branch_i | stored_q);

    assign busy_o       = instr_req_o | (|out_q);
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = pop & ~discard_q[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    always_comb begin
        out_d     = out_q;
        discard_d = discard_q | (branch_i ? out_q : '0);
        placed    = 1'b0;
        if (pop) begin
            out_d     = out_d >> 1;
            discard_d = discard_d >> 1;
        end
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (gnt_fire && !placed && !out_d[i]) begin
                out_d[i]     = 1'b1;
                discard_d[i] = discard_new;
                placed       = 1'b1;
            end
        end
    end

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        stored_d      = stored_q;
        stored_addr_d = stored_addr_q;
        pend_d        = instr_req_o & ~instr_gnt_i;
        if (gnt_fire) begin
            if (discard_new) begin
                fetch_addr_d = branch_i ? branch_addr : stored_addr_q;
            end else begin
                fetch_addr_d = instr_addr_o + 32'd4;
            end
            stored_d = 1'b0;
        end else if (branch_i) begin
            if (pend_q) begin
                stored_d      = 1'b1;
                stored_addr_d = branch_addr;
            end else begin
                fetch_addr_d = branch_addr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '0;
            discard_q     <= '0;
            pend_q        <= 1'b0;
            stored_q      <= 1'b0;
            stored_addr_q <= '0;
            fetch_addr_q  <= '0;
        end else begin
            out_q         <= out_d;
            discard_q     <= discard_d;
            pend_q        <= pend_d;
            stored_q      <= stored_d;
            stored_addr_q <= stored_addr_d;
            fetch_addr_q  <= fetch_addr_d;
        end
    end

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Self-checking bench for ibex_prefetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ibex_prefetch_ctrl;

    localparam int N = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_i = 1'b0;
    logic          branch_i = 1'b0;
    logic [31:0]   addr_i = '0;
    logic          busy_o;
    logic          instr_req_o;
    logic          instr_gnt_i = 1'b0;
    logic [31:0]   instr_addr_o;
    logic          instr_rvalid_i = 1'b0;
    logic [31:0]   instr_rdata_i = '0;
    logic          instr_err_i = 1'b0;
    logic [N-1:0]  fifo_busy_i = '0;
    logic          fifo_clear_o;
    logic          fifo_valid_o;
    logic [31:0]   fifo_addr_o;
    logic [31:0]   fifo_rdata_o;
    logic          fifo_err_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ibex_prefetch_ctrl #(.NUM_REQS(N)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Apply one cycle of stimulus and let combinational outputs settle.
    task automatic drive(input logic req, input logic br, input logic [31:0] a,
                         input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic er);
        req_i = req; branch_i = br; addr_i = a; instr_gnt_i = gnt;
        instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
        #2;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Observation vector: {req, busy, clear, valid, err, instr_addr}
    function automatic logic [36:0] obs();
        return {instr_req_o, busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o, instr_addr_o};
    endfunction

    task automatic test_reset;
        rst_i = 1'b1;
        idle();
        tick(); tick();
        rst_i = 1'b0;
        idle();
        chk_cnt++;
        if (obs() !== {5'b00000, 32'h0}) $display("FAIL reset_outputs got %h exp %h", obs(), {5'b00000, 32'h0});
        else pass_cnt++;
        chk_cnt++;
        if ({fifo_addr_o, fifo_rdata_o} !== 64'h0) $display("FAIL reset_fifo_data got %h exp 0", {fifo_addr_o, fifo_rdata_o});
        else pass_cnt++;
    endtask

    task automatic test_sequential;
        drive(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11100, 32'h100}) $display("FAIL seq_branch got %h exp %h", obs(), {5'b11100, 32'h100});
        else pass_cnt++;
        chk_cnt++;
        if (fifo_addr_o !== 32'h100) $display("FAIL seq_fifo_addr got %h exp 00000100", fifo_addr_o);
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11010, 32'h104} || fifo_rdata_o !== 32'hA)
            $display("FAIL seq_resp_a got %h/%h exp %h/0000000a", obs(), fifo_rdata_o, {5'b11010, 32'h104});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11010, 32'h108} || fifo_rdata_o !== 32'hB)
            $display("FAIL seq_resp_b got %h/%h exp %h/0000000b", obs(), fifo_rdata_o, {5'b11010, 32'h108});
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01010, 32'h10C}) $display("FAIL seq_drain got %h exp %h", obs(), {5'b01010, 32'h10C});
        else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_pending_branch;
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11100, 32'h100}) $display("FAIL pend_first got %h exp %h", obs(), {5'b11100, 32'h100});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b1, 32'h202, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11100, 32'h100}) $display("FAIL pend_hold_branch got %h exp %h", obs(), {5'b11100, 32'h100});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h100}) $display("FAIL pend_hold got %h exp %h", obs(), {5'b11000, 32'h100});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h100}) $display("FAIL pend_grant got %h exp %h", obs(), {5'b11000, 32'h100});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h200}) $display("FAIL pend_drop_stale got %h exp %h", obs(), {5'b11000, 32'h200});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h200}) $display("FAIL pend_target got %h exp %h", obs(), {5'b11000, 32'h200});
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01010, 32'h204} || fifo_rdata_o !== 32'h2222)
            $display("FAIL pend_target_resp got %h/%h exp %h/00002222", obs(), fifo_rdata_o, {5'b01010, 32'h204});
        else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_outstanding_branch;
        drive(1'b1, 1'b1, 32'h280, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h284}) $display("FAIL ob_second got %h exp %h", obs(), {5'b11000, 32'h284});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01100, 32'h300}) $display("FAIL ob_full_branch got %h exp %h", obs(), {5'b01100, 32'h300});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h111, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01000, 32'h300}) $display("FAIL ob_drop1 got %h exp %h", obs(), {5'b01000, 32'h300});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h222, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h300}) $display("FAIL ob_drop2 got %h exp %h", obs(), {5'b11000, 32'h300});
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h333, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01010, 32'h304} || fifo_rdata_o !== 32'h333)
            $display("FAIL ob_first_fwd got %h/%h exp %h/00000333", obs(), fifo_rdata_o, {5'b01010, 32'h304});
        else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_fifo_full;
        fifo_busy_i = '1;
        drive(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01000, 32'h404}) $display("FAIL full_stall got %h exp %h", obs(), {5'b01000, 32'h404});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h444, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01010, 32'h404}) $display("FAIL full_resp got %h exp %h", obs(), {5'b01010, 32'h404});
        else pass_cnt++;
        tick();
        fifo_busy_i = '0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11000, 32'h404}) $display("FAIL full_resume got %h exp %h", obs(), {5'b11000, 32'h404});
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h555, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_error;
        drive(1'b1, 1'b1, 32'h101, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b11100, 32'h100}) $display("FAIL err_align got %h exp %h", obs(), {5'b11100, 32'h100});
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB0, 1'b1);
        chk_cnt++;
        if (obs() !== {5'b11011, 32'h108} || fifo_rdata_o !== 32'hB0)
            $display("FAIL err_forward got %h/%h exp %h/000000b0", obs(), fifo_rdata_o, {5'b11011, 32'h108});
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 1'b0);
        chk_cnt++;
        if (obs() !== {5'b01010, 32'h10C}) $display("FAIL err_continue got %h exp %h", obs(), {5'b01010, 32'h10C});
        else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        rst_i = 1'b1;
        idle();
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h666, 1'b0);
            chk_cnt++;
            if (obs() !== {5'b00000, 32'h0}) $display("FAIL rst_mid_%0d got %h exp %h", k, obs(), {5'b00000, 32'h0});
            else pass_cnt++;
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          disc;
    } ent_t;

    task automatic test_random;
        ent_t        mq[$];
        bit          m_pend = 0, m_stored = 0;
        logic [31:0] m_pend_addr = '0, m_stored_addr = '0, m_fetch = '0;
        logic        req, br, gnt, rv, er, ereq, evalid, ebusy, d;
        logic [31:0] a, rd, tgt, eaddr;
        logic [N-1:0] fb;
        int          n;
        bit          newreq;

        rst_i = 1'b1;
        idle();
        tick();
        rst_i = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n   = mq.size();
            req = ($urandom_range(0, 9) < 8);
            br  = ($urandom_range(0, 11) == 0);
            a   = $urandom;
            gnt = ($urandom_range(0, 9) < 6);
            fb  = N'($urandom);
            rv  = (n > 0) && ($urandom_range(0, 1) == 1);
            rd  = rv ? (mq[0].addr ^ 32'hC0DE_0000) : $urandom;
            er  = rv ? mq[0].addr[3] : 1'b0;

            tgt    = {a[31:2], 2'b00};
            newreq = req && (n < N) && (br || !fb[N-1] || n == 0);
            ereq   = newreq || m_pend;
            eaddr  = m_pend ? m_pend_addr : (br ? tgt : m_fetch);
            evalid = rv && (n > 0) && !mq[0].disc && !br;
            ebusy  = ereq || (n > 0);

            fifo_busy_i = fb;
            drive(req, br, a, gnt, rv, rd, er);
            chk_cnt++;
            if ({instr_req_o, busy_o, fifo_clear_o, fifo_valid_o} !== {ereq, ebusy, br, evalid})
                $display("FAIL rnd_ctrl cyc %0d got %b exp %b", cyc,
                         {instr_req_o, busy_o, fifo_clear_o, fifo_valid_o}, {ereq, ebusy, br, evalid});
            else pass_cnt++;
            if (ereq) begin
                chk_cnt++;
                if (instr_addr_o !== eaddr) $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, instr_addr_o, eaddr);
                else pass_cnt++;
            end
            if (evalid) begin
                chk_cnt++;
                if ({fifo_rdata_o, fifo_err_o} !== {mq[0].addr ^ 32'hC0DE_0000, mq[0].addr[3]})
                    $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, {fifo_rdata_o, fifo_err_o},
                             {mq[0].addr ^ 32'hC0DE_0000, mq[0].addr[3]});
                else pass_cnt++;
            end

            if (br) foreach (mq[i]) mq[i].disc = 1;
            if (rv && n > 0) void'(mq.pop_front());
            if (ereq && gnt) begin
                d = m_pend && (br || m_stored);
                mq.push_back('{eaddr, d});
                m_fetch  = d ? (br ? tgt : m_stored_addr) : eaddr + 32'd4;
                m_pend   = 0;
                m_stored = 0;
            end else begin
                if (br && m_pend) begin
                    m_stored      = 1;
                    m_stored_addr = tgt;
                end else if (br) begin
                    m_fetch = tgt;
                end
                if (ereq) begin
                    m_pend      = 1;
                    m_pend_addr = eaddr;
                end
            end
            tick();
        end
        fifo_busy_i = '0;
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_pending_branch();
        test_outstanding_branch();
        test_fifo_full();
        test_error();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
